// File: rtl/npc_pc_unit.sv
// -----------------------------------------------------------------------------
// npc_pc_unit
//   Next-PC generator fused with the PC register for the MIPS core. Computes
//   the next fetch address for sequential, beq, bne, j, jal and jr flow. It
//   holds the PC while stalled. A return-address stack (RAS) can be built in
//   to check jr targets; the RAS never alters npc.
//
// Optional feature macro:
//   NPC_RAS_EN  - when defined, builds the RAS storage, the ptr/count logic
//                 and the jr miss logic. When undefined, ras_valid, ras_top
//                 and ras_miss are tied to 0.
//
// Parameters:
//   WIDTH      address width (29..64)
//   RESET_PC   PC loaded on reset; zero-extended or truncated to WIDTH
//   RAS_DEPTH  RAS entries, power of two 2..16 (used only with NPC_RAS_EN)
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset (highest priority)
//   stall      in   1 = hold PC, taken and RAS state
//   instr      in   instruction[25:0]: [15:0] branch offset, [25:0] jump index
//   rs         in   GPR[rs], the jr target
//   zero       in   ALU equality flag
//   npc_op     in   000 seq, 001 beq, 010 jal, 011 jr, 100 bne, 101 j, 11x seq
//   pc         out  current fetch address (register)
//   pc_4       out  pc + 4, the link address
//   npc        out  next address (combinational)
//   taken      out  registered: previous accepted op redirected flow
//   ras_valid  out  RAS non-empty
//   ras_top    out  RAS top entry, 0 when empty
//   ras_miss   out  registered pulse: last accepted jr missed the RAS top
//
// Flow control: there is no handshake. A cycle is "accepted" when
// reset == 0 and stall == 0. Only accepted cycles update pc, taken and the
// RAS. A stalled cycle holds all registered state, including ras_miss.
// -----------------------------------------------------------------------------
module npc_pc_unit #(
    parameter int unsigned WIDTH     = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [25:0]      instr,
    input  logic [WIDTH-1:0] rs,
    input  logic             zero,
    input  logic [2:0]       npc_op,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_4,
    output logic [WIDTH-1:0] npc,
    output logic             taken,
    output logic             ras_valid,
    output logic [WIDTH-1:0] ras_top,
    output logic             ras_miss
);

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b001;
    localparam logic [2:0] OP_JAL = 3'b010;
    localparam logic [2:0] OP_JR  = 3'b011;
    localparam logic [2:0] OP_BNE = 3'b100;
    localparam logic [2:0] OP_J   = 3'b101;

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_PC);

    // Elaboration-time parameter sanity checks.
    if (WIDTH < 29 || WIDTH > 64) begin : g_bad_width
        $error("npc_pc_unit: WIDTH must be in 29..64");
    end
    if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("npc_pc_unit: RAS_DEPTH must be a power of two in 2..16");
    end

    logic             accept;
    logic [WIDTH-1:0] btgt;
    logic [WIDTH-1:0] jtgt;
    logic [WIDTH-1:0] boff;

    assign accept = !reset && !stall;

    // Address arithmetic is modulo 2^WIDTH; wrap-around is intentional.
    assign pc_4 = pc + WIDTH'(4);
    // Sign-extended word offset: sext(instr[15:0]) << 2.
    assign boff = {{(WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
    assign btgt = pc_4 + boff;
    // Region jump: keep the upper PC bits from bit 28 up.
    assign jtgt = {pc[WIDTH-1:28], instr[25:0], 2'b00};

    always_comb begin
        npc = pc_4;
        case (npc_op)
            OP_BEQ:  npc = zero ? btgt : pc_4;
            OP_BNE:  npc = zero ? pc_4 : btgt;
            OP_J,
            OP_JAL:  npc = jtgt;
            // jr passes rs through unchanged, even if unaligned.
            OP_JR:   npc = rs;
            default: npc = pc_4;   // seq and reserved 11x
        endcase
    end

    // PC register and redirect flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_VAL;
            taken <= 1'b0;
        end else if (!stall) begin
            pc    <= npc;
            taken <= (npc != pc_4);
        end
    end

`ifdef NPC_RAS_EN
    localparam int unsigned PW = $clog2(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]    ras_ptr;      // next free slot; top is ras_ptr-1
    logic [PW:0]      ras_cnt;      // 0..RAS_DEPTH
    logic [PW-1:0]    ras_top_idx;
    logic             is_jal;
    logic             is_jr;

    assign is_jal      = (npc_op == OP_JAL);
    assign is_jr       = (npc_op == OP_JR);
    // Depth is a power of two, so pointer arithmetic wraps naturally.
    assign ras_top_idx = ras_ptr - PW'(1);
    assign ras_valid   = (ras_cnt != '0);
    assign ras_top     = ras_valid ? ras_mem[ras_top_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            ras_ptr  <= '0;
            ras_cnt  <= '0;
            ras_miss <= 1'b0;
        end else if (!stall) begin
            ras_miss <= 1'b0;
            if (is_jal) begin
                // When full, the push overwrites the oldest entry: the
                // pointer advances onto it and the count stays saturated.
                ras_ptr <= ras_ptr + PW'(1);
                if (ras_cnt != (PW+1)'(RAS_DEPTH)) begin
                    ras_cnt <= ras_cnt + (PW+1)'(1);
                end
            end else if (is_jr) begin
                if (ras_valid) begin
                    ras_ptr  <= ras_top_idx;
                    ras_cnt  <= ras_cnt - (PW+1)'(1);
                    ras_miss <= (ras_top != rs);
                end else begin
                    // Popping an empty stack cannot predict anything.
                    ras_miss <= 1'b1;
                end
            end
        end
    end

    // Entry storage needs no reset; the count gates visibility.
    always_ff @(posedge clk) begin
        if (accept && is_jal) begin
            ras_mem[ras_ptr] <= pc_4;
        end
    end
`else
    assign ras_valid = 1'b0;
    assign ras_top   = '0;
    assign ras_miss  = 1'b0;

    // accept only feeds the RAS, so it is unused in this build.
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_npc_pc_unit.sv
// -----------------------------------------------------------------------------
// tb_npc_pc_unit
//   Directed bench for npc_pc_unit with default parameters (WIDTH=32,
//   RESET_PC=0x3000, RAS_DEPTH=4). Inputs are driven 1 time unit after the
//   rising edge, and outputs are checked at that same point, away from the
//   edge. The RAS scenarios are compiled in only when NPC_RAS_EN is defined.
//   Otherwise the RAS outputs are expected to stay at 0.
// -----------------------------------------------------------------------------
module tb_npc_pc_unit;

    localparam int W = 32;

`ifdef NPC_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b001;
    localparam logic [2:0] OP_JAL = 3'b010;
    localparam logic [2:0] OP_JR  = 3'b011;
    localparam logic [2:0] OP_BNE = 3'b100;
    localparam logic [2:0] OP_J   = 3'b101;

    logic         clk = 1'b0;
    logic         reset;
    logic         stall;
    logic [25:0]  instr;
    logic [W-1:0] rs;
    logic         zero;
    logic [2:0]   npc_op;
    logic [W-1:0] pc;
    logic [W-1:0] pc_4;
    logic [W-1:0] npc;
    logic         taken;
    logic         ras_valid;
    logic [W-1:0] ras_top;
    logic         ras_miss;

    int n_vec = 0;
    int n_err = 0;

    npc_pc_unit dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .instr     (instr),
        .rs        (rs),
        .zero      (zero),
        .npc_op    (npc_op),
        .pc        (pc),
        .pc_4      (pc_4),
        .npc       (npc),
        .taken     (taken),
        .ras_valid (ras_valid),
        .ras_top   (ras_top),
        .ras_miss  (ras_miss)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset  = 1'b0;
        stall  = 1'b0;
        zero   = 1'b0;
        instr  = '0;
        rs     = '0;
        npc_op = OP_SEQ;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_vec++; if (pc !== 32'h0000_3000) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0000_3000); end
        n_vec++; if (pc_4 !== 32'h0000_3004) begin n_err++; $display("FAIL reset_pc_4 got=%h exp=%h", pc_4, 32'h0000_3004); end
        n_vec++; if (taken !== 1'b0) begin n_err++; $display("FAIL reset_taken got=%b exp=0", taken); end
        n_vec++; if (ras_valid !== 1'b0) begin n_err++; $display("FAIL reset_ras_valid got=%b exp=0", ras_valid); end
        n_vec++; if (ras_top !== 32'h0) begin n_err++; $display("FAIL reset_ras_top got=%h exp=0", ras_top); end
        n_vec++; if (ras_miss !== 1'b0) begin n_err++; $display("FAIL reset_ras_miss got=%b exp=0", ras_miss); end
        for (int i = 1; i <= 3; i++) begin
            logic [W-1:0] exp_pc;
            exp_pc = 32'h0000_3000 + 32'(4 * i);
            tick();
            n_vec++; if (pc !== exp_pc) begin n_err++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc); end
            n_vec++; if (taken !== 1'b0) begin n_err++; $display("FAIL seq_taken[%0d] got=%b exp=0", i, taken); end
        end
    endtask

    task automatic test_beq();
        do_reset();
        npc_op = OP_BEQ;
        instr  = 26'h000_FFFF;   // offset -1 word: btgt = 3004 - 4 = 3000
        zero   = 1'b1;
        #1;
        n_vec++; if (npc !== 32'h0000_3000) begin n_err++; $display("FAIL beq_taken_npc got=%h exp=%h", npc, 32'h0000_3000); end
        tick();
        n_vec++; if (pc !== 32'h0000_3000) begin n_err++; $display("FAIL beq_self_loop_pc got=%h exp=%h", pc, 32'h0000_3000); end
        n_vec++; if (taken !== 1'b1) begin n_err++; $display("FAIL beq_taken got=%b exp=1", taken); end
        zero = 1'b0;
        #1;
        n_vec++; if (npc !== 32'h0000_3004) begin n_err++; $display("FAIL beq_not_taken_npc got=%h exp=%h", npc, 32'h0000_3004); end
        tick();
        n_vec++; if (pc !== 32'h0000_3004) begin n_err++; $display("FAIL beq_fall_pc got=%h exp=%h", pc, 32'h0000_3004); end
        n_vec++; if (taken !== 1'b0) begin n_err++; $display("FAIL beq_not_taken got=%b exp=0", taken); end
    endtask

    task automatic test_bne();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        n_vec++; if (pc !== 32'h0000_3010) begin n_err++; $display("FAIL bne_setup_pc got=%h exp=%h", pc, 32'h0000_3010); end
        npc_op = OP_BNE;
        instr  = 26'h000_0004;
        zero   = 1'b1;
        #1;
        n_vec++; if (npc !== 32'h0000_3014) begin n_err++; $display("FAIL bne_not_taken_npc got=%h exp=%h", npc, 32'h0000_3014); end
        zero = 1'b0;
        #1;
        n_vec++; if (npc !== 32'h0000_3024) begin n_err++; $display("FAIL bne_taken_npc got=%h exp=%h", npc, 32'h0000_3024); end
        tick();
        n_vec++; if (pc !== 32'h0000_3024) begin n_err++; $display("FAIL bne_pc got=%h exp=%h", pc, 32'h0000_3024); end
        n_vec++; if (taken !== 1'b1) begin n_err++; $display("FAIL bne_taken got=%b exp=1", taken); end
    endtask

    task automatic test_wrap_jump();
        npc_op = OP_JR;
        rs     = 32'hFFFF_FFFC;
        #1;
        n_vec++; if (npc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL jr_npc got=%h exp=%h", npc, 32'hFFFF_FFFC); end
        tick();
        n_vec++; if (pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL jr_pc got=%h exp=%h", pc, 32'hFFFF_FFFC); end
        npc_op = OP_J;
        instr  = 26'h000_0100;   // upper nibble F kept from pc
        #1;
        n_vec++; if (npc !== 32'hF000_0400) begin n_err++; $display("FAIL j_region_npc got=%h exp=%h", npc, 32'hF000_0400); end
        npc_op = OP_SEQ;
        #1;
        n_vec++; if (pc_4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc_4 got=%h exp=0", pc_4); end
        n_vec++; if (npc !== 32'h0) begin n_err++; $display("FAIL wrap_npc got=%h exp=0", npc); end
        tick();
        n_vec++; if (pc !== 32'h0) begin n_err++; $display("FAIL wrap_pc got=%h exp=0", pc); end
        n_vec++; if (taken !== 1'b0) begin n_err++; $display("FAIL wrap_taken got=%b exp=0", taken); end
        npc_op = 3'b110;         // reserved behaves as sequential
        #1;
        n_vec++; if (npc !== 32'h4) begin n_err++; $display("FAIL reserved_npc got=%h exp=4", npc); end
        npc_op = OP_JR;
        rs     = 32'h0000_3001;  // unaligned passes through
        #1;
        n_vec++; if (npc !== 32'h0000_3001) begin n_err++; $display("FAIL jr_unaligned_npc got=%h exp=%h", npc, 32'h0000_3001); end
        tick();
        n_vec++; if (pc !== 32'h0000_3001) begin n_err++; $display("FAIL jr_unaligned_pc got=%h exp=%h", pc, 32'h0000_3001); end
        n_vec++; if (taken !== 1'b1) begin n_err++; $display("FAIL jr_unaligned_taken got=%b exp=1", taken); end
    endtask

    task automatic test_stall();
        logic [W-1:0] exp_top;
        do_reset();
        npc_op = OP_JAL;
        instr  = 26'h000_0C40;   // jtgt = 0x3100
        stall  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_vec++; if (pc !== 32'h0000_3000) begin n_err++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, pc, 32'h0000_3000); end
            n_vec++; if (taken !== 1'b0) begin n_err++; $display("FAIL stall_taken[%0d] got=%b exp=0", i, taken); end
            n_vec++; if (ras_valid !== 1'b0) begin n_err++; $display("FAIL stall_ras_valid[%0d] got=%b exp=0", i, ras_valid); end
        end
        stall = 1'b0;
        tick();
        exp_top = RAS_ON ? 32'h0000_3004 : 32'h0;
        n_vec++; if (pc !== 32'h0000_3100) begin n_err++; $display("FAIL release_pc got=%h exp=%h", pc, 32'h0000_3100); end
        n_vec++; if (taken !== 1'b1) begin n_err++; $display("FAIL release_taken got=%b exp=1", taken); end
        n_vec++; if (ras_valid !== RAS_ON) begin n_err++; $display("FAIL release_ras_valid got=%b exp=%b", ras_valid, RAS_ON); end
        n_vec++; if (ras_top !== exp_top) begin n_err++; $display("FAIL release_ras_top got=%h exp=%h", ras_top, exp_top); end
        npc_op = OP_SEQ;
        stall  = 1'b1;
        tick();
        n_vec++; if (taken !== 1'b1) begin n_err++; $display("FAIL stall_hold_taken got=%b exp=1", taken); end
        n_vec++; if (pc !== 32'h0000_3100) begin n_err++; $display("FAIL stall_hold_pc got=%h exp=%h", pc, 32'h0000_3100); end
        stall = 1'b0;
    endtask

`ifdef NPC_RAS_EN
    task automatic test_ras();
        do_reset();
        npc_op = OP_JAL;
        for (int k = 0; k < 5; k++) begin
            logic [W-1:0] tgt;
            tgt   = 32'h0000_3100 + 32'(k * 32'h100);
            instr = tgt[27:2];
            tick();
            n_vec++; if (pc !== tgt) begin n_err++; $display("FAIL ras_jal_pc[%0d] got=%h exp=%h", k, pc, tgt); end
        end
        n_vec++; if (ras_top !== 32'h0000_3404) begin n_err++; $display("FAIL ras_full_top got=%h exp=%h", ras_top, 32'h0000_3404); end
        n_vec++; if (ras_valid !== 1'b1) begin n_err++; $display("FAIL ras_full_valid got=%b exp=1", ras_valid); end
        npc_op = OP_JR;
        rs     = 32'h0000_3404;
        tick();
        n_vec++; if (ras_miss !== 1'b0) begin n_err++; $display("FAIL ras_hit_miss got=%b exp=0", ras_miss); end
        n_vec++; if (ras_top !== 32'h0000_3304) begin n_err++; $display("FAIL ras_pop_top got=%h exp=%h", ras_top, 32'h0000_3304); end
        rs = 32'h0000_9999;
        tick();
        n_vec++; if (ras_miss !== 1'b1) begin n_err++; $display("FAIL ras_wrong_miss got=%b exp=1", ras_miss); end
        npc_op = OP_SEQ;
        stall  = 1'b1;
        tick();
        n_vec++; if (ras_miss !== 1'b1) begin n_err++; $display("FAIL ras_stall_hold_miss got=%b exp=1", ras_miss); end
        stall  = 1'b0;
        npc_op = OP_JR;
        rs     = 32'h0000_3204;
        tick();
        n_vec++; if (ras_miss !== 1'b0) begin n_err++; $display("FAIL ras_pop3_miss got=%b exp=0", ras_miss); end
        rs = 32'h0000_3104;      // oldest surviving entry; 3004 was overwritten
        tick();
        n_vec++; if (ras_miss !== 1'b0) begin n_err++; $display("FAIL ras_pop4_miss got=%b exp=0", ras_miss); end
        n_vec++; if (ras_valid !== 1'b0) begin n_err++; $display("FAIL ras_empty_valid got=%b exp=0", ras_valid); end
        n_vec++; if (ras_top !== 32'h0) begin n_err++; $display("FAIL ras_empty_top got=%h exp=0", ras_top); end
        tick();
        n_vec++; if (ras_miss !== 1'b1) begin n_err++; $display("FAIL ras_pop5_empty_miss got=%b exp=1", ras_miss); end
        tick();
        n_vec++; if (ras_miss !== 1'b1) begin n_err++; $display("FAIL ras_pop6_empty_miss got=%b exp=1", ras_miss); end
        n_vec++; if (ras_valid !== 1'b0) begin n_err++; $display("FAIL ras_pop6_valid got=%b exp=0", ras_valid); end
        npc_op = OP_SEQ;
        tick();
        n_vec++; if (ras_miss !== 1'b0) begin n_err++; $display("FAIL ras_miss_clear got=%b exp=0", ras_miss); end
    endtask
`endif

    task automatic test_reset_in_jr();
        logic exp_miss_pre;
        do_reset();
        npc_op = OP_JAL;
        instr  = 26'h000_0C40;
        tick();
        npc_op = OP_JR;
        rs     = 32'h0000_1234;  // not the pushed 0x3004
        tick();
        exp_miss_pre = RAS_ON;
        n_vec++; if (ras_miss !== exp_miss_pre) begin n_err++; $display("FAIL pre_reset_miss got=%b exp=%b", ras_miss, exp_miss_pre); end
        npc_op = OP_JAL;
        instr  = 26'h000_0C80;
        tick();
        npc_op = OP_JR;
        rs     = 32'h0000_5555;
        reset  = 1'b1;
        tick();
        reset  = 1'b0;
        npc_op = OP_SEQ;
        n_vec++; if (pc !== 32'h0000_3000) begin n_err++; $display("FAIL rst_jr_pc got=%h exp=%h", pc, 32'h0000_3000); end
        n_vec++; if (taken !== 1'b0) begin n_err++; $display("FAIL rst_jr_taken got=%b exp=0", taken); end
        n_vec++; if (ras_valid !== 1'b0) begin n_err++; $display("FAIL rst_jr_ras_valid got=%b exp=0", ras_valid); end
        n_vec++; if (ras_miss !== 1'b0) begin n_err++; $display("FAIL rst_jr_ras_miss got=%b exp=0", ras_miss); end
        n_vec++; if (ras_top !== 32'h0) begin n_err++; $display("FAIL rst_jr_ras_top got=%h exp=0", ras_top); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_beq();
        test_bne();
        test_wrap_jump();
        test_stall();
`ifdef NPC_RAS_EN
        test_ras();
`endif
        test_reset_in_jr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
